// File: rtl/bitstream_generator_array.sv
// Multi-channel stochastic bitstream generator: one shared LFSR,
// per-channel rotated compare, windowed output with hold and done.
module bitstream_generator_array #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      CHANNELS   = 4,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'('h1A),
  parameter int unsigned      STREAM_LEN = 2**WIDTH-1,
  parameter int unsigned      ROT_STEP   = 3
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [CHANNELS*(WIDTH+1)-1:0] x_in,
  input  logic                          hold,
  input  logic                          reseed,
  input  logic [WIDTH-1:0]              seed_in,
  output logic [CHANNELS-1:0]           y,
  output logic                          bit_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned XW = WIDTH + 1;
  localparam logic [WIDTH-1:0] TAPS =
    (WIDTH == 16) ? WIDTH'('h2D) : WIDTH'('h1D);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(STREAM_LEN - 1);

  if (WIDTH != 8 && WIDTH != 16) begin : g_bad_width
    $error("WIDTH must be 8 or 16");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_chan
    $error("CHANNELS must be 1..16");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("SEED must be non-zero");
  end
  if (STREAM_LEN < 1 || STREAM_LEN > 2**WIDTH-1) begin : g_bad_len
    $error("STREAM_LEN out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          lfsr_q, lfsr_d;
  logic [WIDTH-1:0]          seed_q, seed_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic [CHANNELS*XW-1:0]    x_q, x_d;
  logic                      fb;

  assign fb = ^(lfsr_q & TAPS);

  // Next-state: window sequencing, LFSR stepping and seed capture.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x_in;
          lfsr_d  = seed_q;
          cnt_d   = '0;
          state_d = S_RUN;
        end
        if (reseed) begin
          seed_d = (seed_in == '0) ? SEED : seed_in;
        end
      end
      S_RUN: begin
        if (!hold) begin
          lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous return to the reset seed.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      seed_q  <= SEED;
      cnt_q   <= '0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign bit_valid = (state_q == S_RUN) & ~hold;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam int unsigned SH = (k * ROT_STEP) % WIDTH;
    logic [WIDTH-1:0] r;
    assign r = (lfsr_q << SH) | (lfsr_q >> (WIDTH - SH));
    assign y[k] = bit_valid & ({1'b0, r} < x_q[k*XW +: XW]);
  end

endmodule

// File: tb/tb_bitstream_generator_array.sv
// Directed bench for bitstream_generator_array with a window-level
// reference model compared against the outputs every cycle.
module tb_bitstream_generator_array;

  localparam int LEN = 255;
  localparam logic [7:0] SEED = 8'h1A;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic        reseed = 1'b0;
  logic [35:0] x_in = '0;
  logic [7:0]  seed_in = '0;
  logic [3:0]  y;
  logic        bit_valid, busy, done;

  always #5 clk = ~clk;

  bitstream_generator_array dut (
    .clk(clk), .n_rst(n_rst), .start(start), .x_in(x_in),
    .hold(hold), .reseed(reseed), .seed_in(seed_in),
    .y(y), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_at(input logic [7:0] s,
                                         input int n);
    logic [7:0] v;
    v = s;
    for (int i = 0; i < n; i++)
      v = {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
    return v;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v,
                                      input int s);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < s; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [35:0] px(input int a, input int b,
                                     input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  // Window model: phase 0 idle, 1 emitting, 2 done cycle.
  int         ph;
  int         idx;
  logic [7:0] m_seed, w_seed;
  logic [8:0] m_x [4];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ph     <= 0;
      idx    <= 0;
      m_seed <= SEED;
      w_seed <= SEED;
      for (int k = 0; k < 4; k++) m_x[k] <= '0;
    end else begin
      case (ph)
        0: begin
          if (start) begin
            w_seed <= m_seed;
            idx    <= 0;
            ph     <= 1;
            for (int k = 0; k < 4; k++) m_x[k] <= x_in[k*9 +: 9];
          end
          if (reseed) m_seed <= (seed_in == 0) ? SEED : seed_in;
        end
        1: if (!hold) begin
          idx <= idx + 1;
          if (idx + 1 == LEN) ph <= 2;
        end
        default: ph <= 0;
      endcase
    end
  end

  logic [3:0] ey;
  logic       ev;
  always @(negedge clk) begin
    ev = (ph == 1) && !hold && n_rst;
    for (int k = 0; k < 4; k++)
      ey[k] = ev &&
        ({1'b0, rotl(lfsr_at(w_seed, idx), (k * 3) % 8)} < m_x[k]);
    check("y", y, ey);
    check("bit_valid", bit_valid, ev);
    check("busy", busy, ph != 0);
    check("done", done, ph == 2);
  end

  logic [3:0] seq[$];
  logic [3:0] base[$];
  int         ones[4];
  int         dc, nv;

  function automatic int seq_diff();
    int d;
    d = (seq.size() == base.size()) ? 0 : 1000;
    for (int i = 0; i < seq.size() && i < base.size(); i++)
      if (seq[i] !== base[i]) d++;
    return d;
  endfunction

  task automatic window(input logic [35:0] x, input int hold_at,
                        input int hold_len, input int inj_c,
                        input int abort_c, output int done_c,
                        output int nvalid);
    seq.delete();
    for (int k = 0; k < 4; k++) ones[k] = 0;
    nvalid = 0;
    done_c = -1;
    @(posedge clk); #1;
    x_in = x;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x_in = ~x;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (bit_valid === 1'b1) begin
        seq.push_back(y);
        nvalid++;
        for (int k = 0; k < 4; k++) ones[k] += int'(y[k]);
      end
      if (c == abort_c) begin
        @(posedge clk); #3;
        n_rst = 1'b0;
        #1;
        check("rst_y", y, 0);
        check("rst_valid", bit_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk); #3;
        n_rst = 1'b1;
        break;
      end
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
      hold    = (c + 1 > hold_at) && (c + 1 <= hold_at + hold_len);
      start   = (c + 1 == inj_c);
      reseed  = (c + 1 == inj_c);
      seed_in = 8'h55;
    end
    hold = 1'b0;
    start = 1'b0;
    reseed = 1'b0;
    if (done_c < 0 && abort_c == 0) check("done_timeout", 0, 1);
  endtask

  task automatic do_reseed(input logic [7:0] v);
    @(posedge clk); #1;
    reseed = 1'b1;
    seed_in = v;
    @(posedge clk); #1;
    reseed = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_y", y, 0);
    check("reset_valid", bit_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(posedge clk); #3;
    n_rst = 1'b1;

    check("model_step01", lfsr_at(8'h01, 1), 8'h80);
    check("model_step1a", lfsr_at(SEED, 1), 8'h0D);
    check("model_period", lfsr_at(SEED, LEN), SEED);

    window(px(128, 128, 128, 128), 0, 0, 0, 0, dc, nv);
    base = seq;
    check("base_done_cyc", dc, 256);
    check("base_nvalid", nv, 255);
    for (int k = 0; k < 4; k++) check("base_ones", ones[k], 127);
    @(negedge clk);
    check("busy_fall", busy, 0);

    window(px(0, 1, 2, 256), 0, 0, 0, 0, dc, nv);
    check("edge_ones0", ones[0], 0);
    check("edge_ones1", ones[1], 0);
    check("edge_ones2", ones[2], 1);
    check("edge_ones3", ones[3], 255);

    window(px(128, 128, 128, 128), 50, 10, 0, 0, dc, nv);
    check("hold_done_cyc", dc, 266);
    check("hold_nvalid", nv, 255);
    for (int k = 0; k < 4; k++) check("hold_ones", ones[k], 127);
    check("hold_seq", seq_diff(), 0);

    do_reseed(8'h01);
    window(px(2, 2, 2, 2), 0, 0, 0, 0, dc, nv);
    check("seed1_bit0", seq[0][0], 1);
    check("seed1_bit1", seq[1][0], 0);
    check("seed1_ones0", ones[0], 1);

    do_reseed(8'h00);
    window(px(128, 128, 128, 128), 0, 0, 0, 0, dc, nv);
    check("reseed0_seq", seq_diff(), 0);

    window(px(128, 128, 128, 128), 0, 0, 101, 0, dc, nv);
    check("inj_done_cyc", dc, 256);
    check("inj_nvalid", nv, 255);
    check("inj_seq", seq_diff(), 0);
    window(px(128, 128, 128, 128), 0, 0, 0, 0, dc, nv);
    check("inj_next_seq", seq_diff(), 0);

    window(px(128, 128, 128, 128), 0, 0, 0, 41, dc, nv);
    check("abort_nodone", dc, -1);
    window(px(128, 128, 128, 128), 0, 0, 0, 0, dc, nv);
    check("post_rst_seq", seq_diff(), 0);
    check("post_rst_done", dc, 256);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
